// File: rtl/if_id_queue.sv
// IF/ID decoupling FIFO: buffers {PC+4, instruction} pairs between fetch and decode,
// drops everything on a taken branch, and raises full as the fetch freeze.
module if_id_queue #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic [31:0]   if_pc,
  input  logic [31:0]   if_instruction,
  input  logic          pop,
  output logic          full,
  output logic          id_valid,
  output logic [31:0]   id_pc,
  output logic [31:0]   id_instruction,
  output logic [CW-1:0] count,
  output logic          ovf
);
  localparam int AW = CW - 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          pop_eff, push_eff;

  assign pop_eff  = pop & (count != '0);
  // full accepts a push only when the head leaves in the same cycle
  assign push_eff = push & ((count != CW'(DEPTH)) | pop_eff);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_eff) wr_ptr <= wr_ptr + 1'b1;
      if (pop_eff)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push_eff) - CW'(pop_eff);
      if (push & ~push_eff) ovf <= 1'b1;
    end
  end

  // storage needs no reset; occupancy alone decides what is valid
  always_ff @(posedge clk) begin
    if (push_eff & ~flush) mem[wr_ptr] <= '{pc: if_pc, instr: if_instruction};
  end

  assign full           = (count == CW'(DEPTH));
  assign id_valid       = (count != '0);
  assign id_pc          = id_valid ? mem[rd_ptr].pc    : 32'h0;
  assign id_instruction = id_valid ? mem[rd_ptr].instr : 32'h0;
endmodule

// File: tb/tb_if_id_queue.sv
// Bench for if_id_queue: vector table, directed corner sequences, and random traffic
// against a queue-based reference model.
module tb_if_id_queue;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          flush = 1'b0, push = 1'b0, pop = 1'b0;
  logic [31:0]   if_pc = '0, if_instruction = '0;
  logic          full, id_valid, ovf;
  logic [31:0]   id_pc, id_instruction;
  logic [CW-1:0] count;

  int checks = 0;
  int errors = 0;

  if_id_queue #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .push(push), .if_pc(if_pc),
    .if_instruction(if_instruction), .pop(pop), .full(full), .id_valid(id_valid),
    .id_pc(id_pc), .id_instruction(id_instruction), .count(count), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          fl, pu, po;
    logic [31:0] pc, ins;
    int          ecnt;
    logic [31:0] epc, eins;
    bit          eovf;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // expected full/valid follow from the expected occupancy
  task automatic check_state(input string tag, input int ecnt, input logic [31:0] epc,
                             input logic [31:0] eins, input bit eovf);
    chk({tag, ".count"}, 64'(count), 64'(ecnt));
    chk({tag, ".full"}, 64'(full), 64'(ecnt == DEPTH));
    chk({tag, ".valid"}, 64'(id_valid), 64'(ecnt != 0));
    chk({tag, ".pc"}, 64'(id_pc), 64'(epc));
    chk({tag, ".instr"}, 64'(id_instruction), 64'(eins));
    chk({tag, ".ovf"}, 64'(ovf), 64'(eovf));
  endtask

  task automatic cyc(input bit f, input bit pu, input bit po,
                     input logic [31:0] pc, input logic [31:0] ins);
    flush = f; push = pu; pop = po; if_pc = pc; if_instruction = ins;
    @(posedge clk); #1;
    flush = 0; push = 0; pop = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst = 0; #3; rst = 1; #1;
  endtask

  vec_t tbl [10];
  logic [63:0] q[$];
  bit          movf;

  initial begin
    tbl[0] = '{0,1,0, 32'd4,  32'h20010005, 1, 32'd4,  32'h20010005, 0};
    tbl[1] = '{0,1,0, 32'd8,  32'h20020007, 2, 32'd4,  32'h20010005, 0};
    tbl[2] = '{0,1,0, 32'd12, 32'h00221820, 3, 32'd4,  32'h20010005, 0};
    tbl[3] = '{0,1,0, 32'd16, 32'hAC030000, 4, 32'd4,  32'h20010005, 0};
    tbl[4] = '{0,1,0, 32'd99, 32'hDEADBEEF, 4, 32'd4,  32'h20010005, 1};
    tbl[5] = '{0,0,1, 32'd0,  32'h0,        3, 32'd8,  32'h20020007, 1};
    tbl[6] = '{0,0,1, 32'd0,  32'h0,        2, 32'd12, 32'h00221820, 1};
    tbl[7] = '{0,0,1, 32'd0,  32'h0,        1, 32'd16, 32'hAC030000, 1};
    tbl[8] = '{0,0,1, 32'd0,  32'h0,        0, 32'd0,  32'h0,        1};
    tbl[9] = '{0,0,1, 32'd0,  32'h0,        0, 32'd0,  32'h0,        1};

    #12; check_state("reset", 0, 0, 0, 0);
    rst = 1; #1;

    foreach (tbl[i]) begin
      cyc(tbl[i].fl, tbl[i].pu, tbl[i].po, tbl[i].pc, tbl[i].ins);
      check_state($sformatf("vec%0d", i), tbl[i].ecnt, tbl[i].epc, tbl[i].eins, tbl[i].eovf);
    end

    // full queue: push and pop together
    do_reset();
    for (int k = 1; k <= 4; k++) cyc(0, 1, 0, 32'(4*k), 32'(4*k));
    cyc(0, 1, 1, 32'd20, 32'h08000000);
    check_state("fullpp", 4, 32'd8, 32'd8, 0);
    cyc(0, 0, 1, 0, 0); check_state("fullpp.p1", 3, 32'd12, 32'd12, 0);
    cyc(0, 0, 1, 0, 0); check_state("fullpp.p2", 2, 32'd16, 32'd16, 0);
    cyc(0, 0, 1, 0, 0); check_state("fullpp.p3", 1, 32'd20, 32'h08000000, 0);
    cyc(0, 0, 1, 0, 0); check_state("fullpp.p4", 0, 0, 0, 0);

    // flush with push and pop at occupancy 3
    for (int k = 1; k <= 3; k++) cyc(0, 1, 0, 32'(100+k), 32'(200+k));
    cyc(1, 1, 1, 32'd77, 32'd77);
    check_state("flush", 0, 0, 0, 0);
    cyc(0, 1, 0, 32'd50, 32'h1234);
    check_state("postflush", 1, 32'd50, 32'h1234, 0);
    cyc(0, 0, 1, 0, 0);

    // wrap-around with concurrent push/pop
    for (int k = 1; k <= 10; k++) begin
      cyc(0, 1, 1, 32'(4*k), 32'(4*k));
      check_state($sformatf("wrap%0d", k), 1, 32'(4*k), 32'(4*k), 0);
    end
    cyc(0, 0, 1, 0, 0); check_state("wrap.end", 0, 0, 0, 0);

    // async reset between edges
    cyc(0, 1, 0, 32'd1, 32'd1); cyc(0, 1, 0, 32'd2, 32'd2);
    #2 rst = 0; #1;
    check_state("asyncrst", 0, 0, 0, 0);
    #2 rst = 1;
    @(posedge clk); #1;
    cyc(0, 1, 0, 32'd60, 32'd61);
    check_state("afterrst", 1, 32'd60, 32'd61, 0);
    cyc(0, 0, 1, 0, 0);

    // random traffic against a queue model
    q.delete(); movf = 0;
    for (int n = 0; n < 400; n++) begin
      bit f, pu, po, pe, ue;
      logic [31:0] pc, ins;
      logic [63:0] hd;
      f = ($urandom_range(0, 19) == 0);
      pu = $urandom_range(0, 1); po = ($urandom_range(0, 2) == 0);
      pc = $urandom; ins = $urandom;
      if (f) q.delete();
      else begin
        pe = po && (q.size() > 0);
        ue = pu && (q.size() < DEPTH || pe);
        if (pu && !ue) movf = 1;
        if (pe) void'(q.pop_front());
        if (ue) q.push_back({pc, ins});
      end
      cyc(f, pu, po, pc, ins);
      hd = (q.size() > 0) ? q[0] : 64'h0;
      check_state($sformatf("rnd%0d", n), q.size(), hd[63:32], hd[31:0], movf);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
